// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control unit for the RV32I core.
// Sequences fetch/decode/execute/memory/writeback. It stalls on the memory
// ready handshake, traps illegal/ECALL/EBREAK into a halt state and keeps a
// retired-instruction counter.
//
// Ports
//   clk, rstn          clock (rising edge), async active-low reset
//   instr              current instruction register contents
//   alu_zero           ALU zero flag (branch resolution)
//   mem_ready          memory completes the current request this cycle
//   trap_clr           pulse to leave TRAP
//   imm_src            immediate format (I=0 S=1 B=2 U=3 J=4)
//   pc_we, instr_we, rf_we, mem_we, mem_req   write enables / memory request
//   mem_addr_src       0 = PC, 1 = RESULT
//   ra1, ra2, wa3      register file addresses sliced from instr
//   alu_a_src          0 PC, 1 PC_BUF, 2 RD1, 3 RD1_BUF, 4 ZERO
//   alu_b_src          0 RD2_BUF, 1 IMM, 2 FOUR
//   result_src         0 ALU_RESULT_BUF, 1 DATA_BUF, 2 ALU_RESULT
//   alu_op             0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND
//   retire, instret    completion pulse and retired-instruction count
//   trap, trap_cause   TRAP indication, cause 0 none 1 illegal 2 ECALL 3 EBREAK
//   state_o            current state (debug)
module multicycle_ctrl #(
  parameter bit          MEM_WAIT_EN  = 1'b1,
  parameter bit          TRAP_EN      = 1'b1,
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [31:0]             instr,
  input  logic                    alu_zero,
  input  logic                    mem_ready,
  input  logic                    trap_clr,
  output logic [2:0]              imm_src,
  output logic                    pc_we,
  output logic                    mem_addr_src,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    instr_we,
  output logic                    rf_we,
  output logic [4:0]              ra1,
  output logic [4:0]              ra2,
  output logic [4:0]              wa3,
  output logic [2:0]              alu_a_src,
  output logic [1:0]              alu_b_src,
  output logic [1:0]              result_src,
  output logic [3:0]              alu_op,
  output logic                    retire,
  output logic [RETIRE_CNT_W-1:0] instret,
  output logic                    trap,
  output logic [1:0]              trap_cause,
  output logic [3:0]              state_o
);

  localparam logic [2:0] INSTR_FORMAT_I = 3'd0, INSTR_FORMAT_S = 3'd1,
                         INSTR_FORMAT_B = 3'd2, INSTR_FORMAT_U = 3'd3,
                         INSTR_FORMAT_J = 3'd4;
  localparam logic       MEM_ADDR_SRC_PC = 1'b0, MEM_ADDR_SRC_RESULT = 1'b1;
  localparam logic [2:0] ALU_A_SRC_PC = 3'd0, ALU_A_SRC_PC_BUF = 3'd1,
                         ALU_A_SRC_RD1 = 3'd2, ALU_A_SRC_RD1_BUF = 3'd3,
                         ALU_A_SRC_ZERO = 3'd4;
  localparam logic [1:0] ALU_B_SRC_RD2_BUF = 2'd0, ALU_B_SRC_IMM = 2'd1,
                         ALU_B_SRC_FOUR = 2'd2;
  localparam logic [1:0] RESULT_SRC_ALU_RESULT_BUF = 2'd0,
                         RESULT_SRC_DATA_BUF = 2'd1,
                         RESULT_SRC_ALU_RESULT = 2'd2;
  localparam logic       ALU_CTRL_ADD = 1'b0, ALU_CTRL_OP = 1'b1;
  localparam logic [3:0] ALU_OP_ADD = 4'd0, ALU_OP_SUB = 4'd1, ALU_OP_SLL = 4'd2,
                         ALU_OP_SLT = 4'd3, ALU_OP_SLTU = 4'd4, ALU_OP_XOR = 4'd5,
                         ALU_OP_SRL = 4'd6, ALU_OP_SRA = 4'd7, ALU_OP_OR = 4'd8,
                         ALU_OP_AND = 4'd9;
  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_REG = 7'b0110011, OPC_IMM = 7'b0010011,
                         OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                         OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_BRANCH = 7'b1100011, OPC_FENCE = 7'b0001111,
                         OPC_SYS = 7'b1110011;
  localparam logic [RETIRE_CNT_W-1:0] CNT_ONE = RETIRE_CNT_W'(1);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_LOAD = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_STORE = 4'd5, S_EXECUTE_R = 4'd6, S_ALU_WB = 4'd7,
    S_EXECUTE_I = 4'd8, S_JAL = 4'd9, S_JALR = 4'd10, S_LUI = 4'd11,
    S_AUIPC = 4'd12, S_BRANCH = 4'd13, S_TRAP = 4'd14
  } state_e;

  state_e                  state_q;
  logic [RETIRE_CNT_W-1:0] instret_q;
  logic [1:0]              trap_cause_q;

  logic       rdy;
  logic [6:0] opcode;
  logic       is_load, is_store, is_reg, is_imm, is_jal, is_jalr;
  logic       is_lui, is_auipc, is_branch, is_fence, is_sys;
  logic       is_ecall, is_ebreak, illegal;
  logic [1:0] cause_d;
  logic       alu_ctrl;

  assign rdy    = mem_ready | ~MEM_WAIT_EN;
  assign opcode = instr[6:0];

  always_comb begin
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_reg    = (opcode == OPC_REG);
    is_imm    = (opcode == OPC_IMM);
    is_jal    = (opcode == OPC_JAL);
    is_jalr   = (opcode == OPC_JALR);
    is_lui    = (opcode == OPC_LUI);
    is_auipc  = (opcode == OPC_AUIPC);
    is_branch = (opcode == OPC_BRANCH);
    is_fence  = (opcode == OPC_FENCE);
    is_sys    = (opcode == OPC_SYS);
    is_ecall  = (instr == 32'h0000_0073);
    is_ebreak = (instr == 32'h0010_0073);
    // Every opcode constant ends in 2'b11, so a bad low pair is also "unknown".
    illegal   = ~(is_load | is_store | is_reg | is_imm | is_jal | is_jalr |
                  is_lui | is_auipc | is_branch | is_fence | is_sys) |
                (is_sys & ~is_ecall & ~is_ebreak);
    cause_d   = illegal ? 2'd1 : is_ecall ? 2'd2 : is_ebreak ? 2'd3 : 2'd0;

    imm_src = INSTR_FORMAT_I;
    if (is_store)              imm_src = INSTR_FORMAT_S;
    if (is_branch)             imm_src = INSTR_FORMAT_B;
    if (is_lui || is_auipc)    imm_src = INSTR_FORMAT_U;
    if (is_jal)                imm_src = INSTR_FORMAT_J;
  end

  // Branches reuse the compare ops: funct3[2:1] picks SUB/SLT/SLTU and the
  // polarity is applied to alu_zero in BRANCH.
  always_comb begin
    alu_op = ALU_OP_ADD;
    if (alu_ctrl == ALU_CTRL_OP) begin
      if (is_branch) begin
        case (instr[14:13])
          2'b10:   alu_op = ALU_OP_SLT;
          2'b11:   alu_op = ALU_OP_SLTU;
          default: alu_op = ALU_OP_SUB;
        endcase
      end else begin
        case (instr[14:12])
          3'b000:  alu_op = (is_reg && instr[30]) ? ALU_OP_SUB : ALU_OP_ADD;
          3'b001:  alu_op = ALU_OP_SLL;
          3'b010:  alu_op = ALU_OP_SLT;
          3'b011:  alu_op = ALU_OP_SLTU;
          3'b100:  alu_op = ALU_OP_XOR;
          3'b101:  alu_op = instr[30] ? ALU_OP_SRA : ALU_OP_SRL;
          3'b110:  alu_op = ALU_OP_OR;
          default: alu_op = ALU_OP_AND;
        endcase
      end
    end
  end

  always_comb begin
    pc_we        = 1'b0;
    instr_we     = 1'b0;
    rf_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    retire       = 1'b0;
    mem_addr_src = MEM_ADDR_SRC_PC;
    alu_a_src    = ALU_A_SRC_PC;
    alu_b_src    = ALU_B_SRC_RD2_BUF;
    result_src   = RESULT_SRC_ALU_RESULT;
    alu_ctrl     = ALU_CTRL_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_b_src = ALU_B_SRC_FOUR;
        instr_we  = rdy;
        pc_we     = rdy;
      end
      S_DECODE: begin
        alu_a_src = is_jalr ? ALU_A_SRC_RD1 : ALU_A_SRC_PC_BUF;
        alu_b_src = ALU_B_SRC_IMM;
        retire    = is_fence | ((cause_d != 2'd0) & ~TRAP_EN);
      end
      S_MEM_ADDR: begin
        alu_a_src = ALU_A_SRC_RD1_BUF;
        alu_b_src = ALU_B_SRC_IMM;
      end
      S_MEM_LOAD: begin
        mem_req      = 1'b1;
        mem_addr_src = MEM_ADDR_SRC_RESULT;
        result_src   = RESULT_SRC_ALU_RESULT_BUF;
      end
      S_MEM_WB: begin
        rf_we      = 1'b1;
        result_src = RESULT_SRC_DATA_BUF;
        retire     = 1'b1;
      end
      S_MEM_STORE: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_src = MEM_ADDR_SRC_RESULT;
        result_src   = RESULT_SRC_ALU_RESULT_BUF;
        retire       = rdy;
      end
      S_EXECUTE_R: begin
        alu_a_src = ALU_A_SRC_RD1_BUF;
        alu_ctrl  = ALU_CTRL_OP;
      end
      S_EXECUTE_I: begin
        alu_a_src = ALU_A_SRC_RD1_BUF;
        alu_b_src = ALU_B_SRC_IMM;
        alu_ctrl  = ALU_CTRL_OP;
      end
      S_LUI: begin
        alu_a_src = ALU_A_SRC_ZERO;
        alu_b_src = ALU_B_SRC_IMM;
      end
      S_AUIPC: begin
        alu_a_src = ALU_A_SRC_PC_BUF;
        alu_b_src = ALU_B_SRC_IMM;
      end
      S_JAL, S_JALR: begin
        pc_we      = 1'b1;
        result_src = RESULT_SRC_ALU_RESULT_BUF;
        alu_a_src  = ALU_A_SRC_PC_BUF;
        alu_b_src  = ALU_B_SRC_FOUR;
      end
      S_ALU_WB: begin
        rf_we      = 1'b1;
        result_src = RESULT_SRC_ALU_RESULT_BUF;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_a_src  = ALU_A_SRC_RD1_BUF;
        alu_ctrl   = ALU_CTRL_OP;
        result_src = RESULT_SRC_ALU_RESULT_BUF;
        pc_we      = alu_zero ^ instr[12] ^ instr[14];
        retire     = 1'b1;
      end
      default: ;
    endcase
    // State already sits at FETCH during reset; this also silences FETCH's
    // request so nothing is written while rstn is low.
    if (!rstn) begin
      pc_we    = 1'b0;
      instr_we = 1'b0;
      rf_we    = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_FETCH;
      instret_q    <= '0;
      trap_cause_q <= '0;
    end else begin
      if (retire) instret_q <= instret_q + CNT_ONE;
      case (state_q)
        S_FETCH:     if (rdy) state_q <= S_DECODE;
        S_DECODE: begin
          if (cause_d != 2'd0) begin
            if (TRAP_EN) begin
              state_q      <= S_TRAP;
              trap_cause_q <= cause_d;
            end else begin
              state_q <= S_FETCH;
            end
          end else if (is_load || is_store) state_q <= S_MEM_ADDR;
          else if (is_reg)                  state_q <= S_EXECUTE_R;
          else if (is_imm)                  state_q <= S_EXECUTE_I;
          else if (is_jal)                  state_q <= S_JAL;
          else if (is_jalr)                 state_q <= S_JALR;
          else if (is_lui)                  state_q <= S_LUI;
          else if (is_auipc)                state_q <= S_AUIPC;
          else if (is_branch)               state_q <= S_BRANCH;
          else                              state_q <= S_FETCH;
        end
        S_MEM_ADDR:  state_q <= is_load ? S_MEM_LOAD : S_MEM_STORE;
        S_MEM_LOAD:  if (rdy) state_q <= S_MEM_WB;
        S_MEM_STORE: if (rdy) state_q <= S_FETCH;
        S_EXECUTE_R, S_EXECUTE_I, S_LUI, S_AUIPC, S_JAL, S_JALR:
                     state_q <= S_ALU_WB;
        S_TRAP: begin
          if (trap_clr) begin
            state_q      <= S_FETCH;
            trap_cause_q <= '0;
          end
        end
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  assign instret    = instret_q;
  assign trap_cause = trap_cause_q;
  assign trap       = (state_q == S_TRAP);
  assign state_o    = state_q;
  assign ra1        = instr[19:15];
  assign ra2        = instr[24:20];
  assign wa3        = instr[11:7];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: table of single-instruction runs with
// zero-wait memory, plus hand sequences for stalls, traps, counter wrap and
// reset in the middle of a store.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr;
  logic        alu_zero, mem_ready, trap_clr;
  logic [2:0]  imm_src;
  logic        pc_we, mem_addr_src, mem_req, mem_we, instr_we, rf_we;
  logic [4:0]  ra1, ra2, wa3;
  logic [2:0]  alu_a_src;
  logic [1:0]  alu_b_src, result_src;
  logic [3:0]  alu_op;
  logic        retire;
  logic [3:0]  instret;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [3:0]  state_o;

  multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .TRAP_EN(1'b1), .RETIRE_CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .trap_clr(trap_clr), .imm_src(imm_src),
    .pc_we(pc_we), .mem_addr_src(mem_addr_src), .mem_req(mem_req),
    .mem_we(mem_we), .instr_we(instr_we), .rf_we(rf_we), .ra1(ra1),
    .ra2(ra2), .wa3(wa3), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
    .result_src(result_src), .alu_op(alu_op), .retire(retire),
    .instret(instret), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int unsigned ncyc;
    logic [19:0] seq;      // state per cycle, cycle 0 in the low nibble
    int unsigned n_pc, n_rf, n_mw;
    logic [2:0]  imm;
    logic [3:0]  op2;      // alu_op / srcs in the third cycle
    logic [2:0]  a2;
    logic [1:0]  b2;
    logic [1:0]  rs_last;  // result_src in the final cycle
  } vec_t;

  vec_t vt[14];
  int   tests = 0;
  int   fails = 0;
  int   exp_instret = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    exp_instret = 0;
  endtask

  // Entered just after a negedge with the DUT in FETCH.
  task automatic run_vec(input vec_t v, input int idx);
    logic [19:0] act_seq = '0;
    int unsigned n_pc = 0, n_rf = 0, n_mw = 0, n_iw = 0, n_rt = 0;
    for (int unsigned c = 0; c < v.ncyc; c++) begin
      instr = v.instr; alu_zero = v.zero; mem_ready = 1'b1; trap_clr = 1'b0;
      #1;
      act_seq[4*c +: 4] = state_o;
      n_pc += pc_we; n_rf += rf_we; n_mw += mem_we; n_iw += instr_we; n_rt += retire;
      if (c == 1) chk($sformatf("v%0d imm_src", idx), imm_src, v.imm);
      if (c == 2) begin
        chk($sformatf("v%0d alu_op", idx), alu_op, v.op2);
        chk($sformatf("v%0d alu_a_src", idx), alu_a_src, v.a2);
        chk($sformatf("v%0d alu_b_src", idx), alu_b_src, v.b2);
      end
      if (c == v.ncyc - 1) chk($sformatf("v%0d result_src", idx), result_src, v.rs_last);
      @(negedge clk);
    end
    #1;
    exp_instret++;
    chk($sformatf("v%0d states", idx), act_seq, v.seq);
    chk($sformatf("v%0d pc_we count", idx), n_pc, v.n_pc);
    chk($sformatf("v%0d rf_we count", idx), n_rf, v.n_rf);
    chk($sformatf("v%0d mem_we count", idx), n_mw, v.n_mw);
    chk($sformatf("v%0d instr_we count", idx), n_iw, 1);
    chk($sformatf("v%0d retire count", idx), n_rt, 1);
    chk($sformatf("v%0d regaddr", idx), {ra1, ra2, wa3},
        {v.instr[19:15], v.instr[24:20], v.instr[11:7]});
    chk($sformatf("v%0d instret", idx), instret, exp_instret % 16);
    chk($sformatf("v%0d back to fetch", idx), state_o, 0);
  endtask

  task automatic trap_test(input logic [31:0] ins, input logic [1:0] cause, input logic early_clr);
    int unsigned bad_st = 0, any_we = 0;
    instr = ins; mem_ready = 1'b1; alu_zero = 1'b0; trap_clr = early_clr;
    #1 chk($sformatf("trap %0h fetch", ins), state_o, 0);
    @(negedge clk);
    #1 chk($sformatf("trap %0h decode", ins), state_o, 1);
    chk($sformatf("trap %0h decode retire", ins), retire, 0);
    @(negedge clk);
    trap_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (state_o !== 4'd14 || trap !== 1'b1) bad_st++;
      any_we += pc_we | instr_we | rf_we | mem_we | mem_req | retire;
      @(negedge clk);
    end
    chk($sformatf("trap %0h held", ins), bad_st, 0);
    chk($sformatf("trap %0h quiet", ins), any_we, 0);
    chk($sformatf("trap %0h cause", ins), trap_cause, cause);
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    #1 chk($sformatf("trap %0h clr state", ins), {trap, state_o}, 0);
    chk($sformatf("trap %0h cause cleared", ins), trap_cause, 0);
    chk($sformatf("trap %0h instret", ins), instret, exp_instret % 16);
  endtask

  initial begin
    logic [9:0]  mr_pat = 10'b1100111000;
    logic [39:0] lw_seq = 40'h4333210000;
    logic [39:0] act40  = '0;
    int unsigned n_iw = 0, n_pc = 0, n_rf = 0, n_mw = 0, n_rq = 0, n_as = 0, n_rt = 0;
    logic [31:0] tr_ins[6]   = '{32'h0000_0000, 32'h0000_0073, 32'h0010_0073,
                                 32'h0020_0073, 32'h0050_0091, 32'h0000_007F};
    logic [1:0]  tr_cause[6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1};
    logic        tr_early[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    vt[0]  = '{32'h0050_0093, 1'b0, 4, 20'h07810, 1, 1, 0, 3'd0, 4'd0, 3'd3, 2'd1, 2'd0}; // ADDI
    vt[1]  = '{32'h4020_81B3, 1'b0, 4, 20'h07610, 1, 1, 0, 3'd0, 4'd1, 3'd3, 2'd0, 2'd0}; // SUB
    vt[2]  = '{32'h4030_D093, 1'b0, 4, 20'h07810, 1, 1, 0, 3'd0, 4'd7, 3'd3, 2'd1, 2'd0}; // SRAI
    vt[3]  = '{32'h1234_52B7, 1'b0, 4, 20'h07B10, 1, 1, 0, 3'd3, 4'd0, 3'd4, 2'd1, 2'd0}; // LUI
    vt[4]  = '{32'h0000_1297, 1'b0, 4, 20'h07C10, 1, 1, 0, 3'd3, 4'd0, 3'd1, 2'd1, 2'd0}; // AUIPC
    vt[5]  = '{32'h0080_00EF, 1'b0, 4, 20'h07910, 2, 1, 0, 3'd4, 4'd0, 3'd1, 2'd2, 2'd0}; // JAL
    vt[6]  = '{32'h0001_00E7, 1'b0, 4, 20'h07A10, 2, 1, 0, 3'd0, 4'd0, 3'd1, 2'd2, 2'd0}; // JALR
    vt[7]  = '{32'h0020_8463, 1'b1, 3, 20'h00D10, 2, 0, 0, 3'd2, 4'd1, 3'd3, 2'd0, 2'd0}; // BEQ taken
    vt[8]  = '{32'h0020_9463, 1'b1, 3, 20'h00D10, 1, 0, 0, 3'd2, 4'd1, 3'd3, 2'd0, 2'd0}; // BNE not
    vt[9]  = '{32'h0020_C463, 1'b0, 3, 20'h00D10, 2, 0, 0, 3'd2, 4'd3, 3'd3, 2'd0, 2'd0}; // BLT taken
    vt[10] = '{32'h0020_F463, 1'b0, 3, 20'h00D10, 1, 0, 0, 3'd2, 4'd4, 3'd3, 2'd0, 2'd0}; // BGEU not
    vt[11] = '{32'h0001_2083, 1'b0, 5, 20'h43210, 1, 1, 0, 3'd0, 4'd0, 3'd3, 2'd1, 2'd1}; // LW
    vt[12] = '{32'h0020_A223, 1'b0, 4, 20'h05210, 1, 0, 1, 3'd1, 4'd0, 3'd3, 2'd1, 2'd0}; // SW
    vt[13] = '{32'h0FF0_000F, 1'b0, 2, 20'h00010, 1, 0, 0, 3'd0, 4'd0, 3'd0, 2'd0, 2'd2}; // FENCE

    // Reset state
    rstn = 1'b0; instr = 32'h0050_0093; alu_zero = 1'b0; mem_ready = 1'b1; trap_clr = 1'b0;
    #2;
    chk("reset state", state_o, 0);
    chk("reset instret", instret, 0);
    chk("reset trap", {trap, trap_cause}, 0);
    chk("reset enables", {pc_we, instr_we, rf_we, mem_we, mem_req, retire}, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("post-reset fetch req", {state_o, mem_req}, 5'b0000_1);

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // 4-bit counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) run_vec(vt[0], 100 + i);
    chk("instret wrap", instret, 1);

    // LW with 3 fetch waits and 2 load waits
    for (int unsigned c = 0; c < 10; c++) begin
      instr = 32'h0001_2083; mem_ready = mr_pat[c];
      #1;
      act40[4*c +: 4] = state_o;
      n_iw += instr_we; n_pc += pc_we; n_rf += rf_we; n_mw += mem_we;
      n_rq += mem_req; n_as += (mem_addr_src & mem_req); n_rt += retire;
      if (c == 9) chk("lw wait result_src", result_src, 1);
      @(negedge clk);
    end
    #1;
    exp_instret++;
    chk("lw wait states", act40, lw_seq);
    chk("lw wait instr_we", n_iw, 1);
    chk("lw wait pc_we", n_pc, 1);
    chk("lw wait rf_we", n_rf, 1);
    chk("lw wait mem_we", n_mw, 0);
    chk("lw wait mem_req", n_rq, 7);
    chk("lw wait addr src", n_as, 3);
    chk("lw wait retire", n_rt, 1);
    chk("lw wait end", {state_o, instret}, {4'd0, 4'(exp_instret)});

    for (int i = 0; i < 6; i++) trap_test(tr_ins[i], tr_cause[i], tr_early[i]);

    // Reset while a store is stalled
    instr = 32'h0020_A223; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("st stall", {state_o, mem_we, retire}, {4'd5, 1'b1, 1'b0});
    @(negedge clk);
    #1 chk("st still", {state_o, mem_we}, {4'd5, 1'b1});
    #1 rstn = 1'b0;
    #1 chk("st reset we", {mem_we, mem_req, retire}, 0);
    chk("st reset state", state_o, 0);
    chk("st reset instret", instret, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    #1 chk("st release", {state_o, mem_req, pc_we}, {4'd0, 1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
